pipe_stage_buf: RTL and testbench

- Parametrised, elastic pipeline-stage register; generalises the fixed per-stage latch interfaces (if/id, id/ex, ex/mem, mem/wb).
- Carries one opaque bundle of DATA_W bits between stages, buffered up to DEPTH entries, with valid/ready handshake and synchronous flush.
- Sits between any two pipeline stages.
- Gives stall back-pressure and squash without per-stage hand-written latch logic.

---
 rtl/pipe_stage_buf.sv | 134 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register.
// A DEPTH-entry circular buffer carrying an opaque DATA_W bundle between two
// pipeline stages with valid/ready handshake and synchronous flush.
// Optional statistics counters are enabled by defining PIPE_STAGE_BUF_STATS_EN.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]         DEPTH_C  = 3'(DEPTH);
  localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) return '0;
    else               return p + 1'b1;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [2:0]        occ_q, occ_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              wr_en;
  logic              push, pop;

  // Handshake flags come only from registered occupancy (plus reset gating).
  always_comb begin
    in_ready  = (occ_q != DEPTH_C) && !RST;
    out_valid = (occ_q != 3'd0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  assign occupancy = occ_q;
  assign out_data  = out_data_q;

  // Next-state for pointers, occupancy and the registered head word; flush wins.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    out_data_d = out_data_q;
    wr_en      = 1'b0;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = 3'd0;
    end else begin
      if (push) begin
        wr_en  = 1'b1;
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      occ_d = occ_q + {2'b00, push} - {2'b00, pop};
      // The new head is either an already-stored entry or the word being
      // pushed right now when the buffer would otherwise run dry.
      if (pop) begin
        if (occ_q >= 3'd2) out_data_d = mem_q[ptr_inc(head_q)];
        else if (push)     out_data_d = in_data;
      end else if ((occ_q == 3'd0) && push) begin
        out_data_d = in_data;
      end
    end
  end

  // Control state and the visible head register; reset drops everything held.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 3'd0;
      out_data_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      out_data_q <= out_data_d;
    end
  end

  // Entry storage; contents are only meaningful while counted in occupancy.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[tail_q] <= in_data;
  end

`ifdef PIPE_STAGE_BUF_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Saturating back-pressure and starvation counters; flush leaves them alone.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != '1))  stall_d  = stall_q + 1'b1;
    if (!out_valid && out_ready && (bubble_q != '1)) bubble_d = bubble_q + 1'b1;
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: two instances (DEPTH=2 with CNT_W=4, DEPTH=3
// with CNT_W=16) share one stimulus stream and are compared every cycle with a
// queue-based reference model. Honours PIPE_STAGE_BUF_STATS_EN.
module tb_pipe_stage_buf;

  localparam int MAX_A = 15;      // 2^4-1
  localparam int MAX_B = 65535;   // 2^16-1

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [2:0]  occ_a, occ_b;
  logic [3:0]  stall_a, bubble_a;
  logic [15:0] stall_b, bubble_b;

  pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) dut_a (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .occupancy(occ_a), .stall_cnt(stall_a), .bubble_cnt(bubble_a)
  );

  pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .occupancy(occ_b), .stall_cnt(stall_b), .bubble_cnt(bubble_b)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference state
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int st_a = 0, bb_a = 0, st_b = 0, bb_b = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Apply the buffer rules to the model at a rising edge.
  task automatic model_edge();
    bit push_a, pop_a, push_b, pop_b;
    push_a = in_valid && !RST && (qa.size() < 2);
    pop_a  = (qa.size() > 0) && out_ready;
    push_b = in_valid && !RST && (qb.size() < 3);
    pop_b  = (qb.size() > 0) && out_ready;
    if (RST) begin
      qa.delete(); qb.delete();
      st_a = 0; bb_a = 0; st_b = 0; bb_b = 0;
    end else begin
      if ((qa.size() > 0) && !out_ready && (st_a < MAX_A)) st_a++;
      if ((qa.size() == 0) && out_ready && (bb_a < MAX_A)) bb_a++;
      if ((qb.size() > 0) && !out_ready && (st_b < MAX_B)) st_b++;
      if ((qb.size() == 0) && out_ready && (bb_b < MAX_B)) bb_b++;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (pop_a)  void'(qa.pop_front());
        if (push_a) qa.push_back(in_data);
        if (pop_b)  void'(qb.pop_front());
        if (push_b) qb.push_back(in_data);
      end
    end
  endtask

  task automatic check_all();
    int es_a, eb_a, es_b, eb_b;
`ifdef PIPE_STAGE_BUF_STATS_EN
    es_a = st_a; eb_a = bb_a; es_b = st_b; eb_b = bb_b;
`else
    es_a = 0; eb_a = 0; es_b = 0; eb_b = 0;
`endif
    chk("a_out_valid", out_valid_a, qa.size() != 0);
    chk("a_occupancy", occ_a, qa.size());
    chk("a_in_ready", in_ready_a, !RST && (qa.size() != 2));
    if (qa.size() != 0) chk("a_out_data", out_data_a, qa[0]);
    chk("a_stall_cnt", stall_a, es_a);
    chk("a_bubble_cnt", bubble_a, eb_a);
    chk("b_out_valid", out_valid_b, qb.size() != 0);
    chk("b_occupancy", occ_b, qb.size());
    chk("b_in_ready", in_ready_b, !RST && (qb.size() != 3));
    if (qb.size() != 0) chk("b_out_data", out_data_b, qb[0]);
    chk("b_stall_cnt", stall_b, es_b);
    chk("b_bubble_cnt", bubble_b, eb_b);
  endtask

  // One clock: drive inputs, let the edge happen, update model, check on negedge.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic f, input logic rs);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    RST       = rs;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  initial begin
    // Reset, then idle
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 1);
    chk("rst_out_data_a", out_data_a, 32'h0);
    chk("rst_out_data_b", out_data_b, 32'h0);
    step(0, 32'h0, 0, 0, 0);
    chk("idle_out_data_a", out_data_a, 32'h0);

    // Single word then a continuous stream
    step(1, 32'hDEADBEEF, 1, 0, 0);
    chk("first_word", out_data_a, 32'hDEADBEEF);
    for (int i = 1; i <= 10; i++) step(1, i, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);

    // Back-pressure: A, B, C offered while the consumer stalls
    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0);
    step(1, 32'hC, 0, 0, 0);
    chk("stall_head", out_data_a, 32'hA);
    step(1, 32'hC, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 1, 0, 0);

    // Flush with a simultaneous push, then a fresh word
    step(1, 32'h1, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0);
    step(1, 32'h5, 0, 1, 0);
    step(1, 32'h6, 1, 0, 0);
    chk("after_flush", out_data_a, 32'h6);
    step(0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 0, 1, 0);   // flush while empty

    // Wrap with alternating out_ready
    for (int i = 0; i < 14; i++) step(1, 32'h100 + i, i[0], 0, 0);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0, 0);

    // Long stall to saturate the narrow counter, flush, then reset
    step(1, 32'h77, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 1, 0);
    step(0, 32'h0, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1);
    step(0, 32'h0, 0, 0, 0);

    // Randomized traffic with varying consumer behaviour
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 200; i++) begin
        step($urandom_range(0, 3) != 0, $urandom,
             $urandom_range(1, 100) <= rdy_pct,
             $urandom_range(0, 40) == 0,
             $urandom_range(0, 250) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
